// File: rtl/xiphos_mem_pkg.sv
// Shared definitions for the RAM4k-side memory engines.
// Provides the RAM geometry constants, the copy-engine state encoding
// and the operation mode encoding.
package xiphos_mem_pkg;

    localparam int ADDR_W = 12;  // 4096-word RAM
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic {
        MODE_COPY = 1'b0,
        MODE_FILL = 1'b1
    } mode_e;

endpackage

// File: rtl/ram4k_copy_engine.sv
// ram4k_copy_engine: block copy / block fill initiator for the RAM4k.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start           request, sampled only while idle
//   mode            0 = copy, 1 = fill
//   src, dst        source / destination base word address
//   len             word count, 0..4096 (ADDR_W+1 bits)
//   fill_val        fill pattern
//   busy            high whenever an operation is in progress (incl. DONE)
//   done            one-cycle completion pulse
//   mem_addr/mem_in/mem_ld  drive the RAM addr/in/ld inputs
//   mem_out         RAM combinational read data
//
// Copy takes two cycles per word (read, then write); fill writes one word
// per cycle. Address pointers wrap modulo 2**ADDR_W. All RAM-side outputs
// are decoded from the state register, so asserting rst_n low removes
// mem_ld immediately without waiting for a clock edge.
module ram4k_copy_engine #(
    parameter int ADDR_W = xiphos_mem_pkg::ADDR_W,
    parameter int DATA_W = xiphos_mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] fill_val,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_ld,
    input  logic [DATA_W-1:0] mem_out
);

    import xiphos_mem_pkg::*;

    state_e              state_q,   state_d;
    mode_e               mode_q,    mode_d;
    logic [ADDR_W-1:0]   src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0]   dst_ptr_q, dst_ptr_d;
    logic [ADDR_W:0]     cnt_q,     cnt_d;
    logic [DATA_W-1:0]   buf_q,     buf_d;
    logic [DATA_W-1:0]   fill_q,    fill_d;

    // Next-state and datapath update.
    always_comb begin
        // NOTE: every signal gets a hold-value default before the case so
        // no path leaves it unassigned (which would infer a latch).
        state_d   = state_q;
        mode_d    = mode_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        fill_d    = fill_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d    = mode_e'(mode);
                    src_ptr_d = src;
                    dst_ptr_d = dst;
                    cnt_d     = len;
                    fill_d    = fill_val;
                    if (len == '0)
                        state_d = ST_DONE;
                    else if (mode_e'(mode) == MODE_FILL)
                        state_d = ST_WR;
                    else
                        state_d = ST_RD;
                end
            end
            ST_RD: begin
                buf_d     = mem_out;
                src_ptr_d = src_ptr_q + 1'b1;  // wraps modulo 2**ADDR_W
                state_d   = ST_WR;
            end
            ST_WR: begin
                dst_ptr_d = dst_ptr_q + 1'b1;
                cnt_d     = cnt_q - 1'b1;
                // Last word when the count is about to reach zero.
                if (cnt_q == (ADDR_W+1)'(1))
                    state_d = ST_DONE;
                else if (mode_q == MODE_FILL)
                    state_d = ST_WR;
                else
                    state_d = ST_RD;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_COPY;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            cnt_q     <= '0;
            buf_q     <= '0;
            fill_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            mode_q    <= mode_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            fill_q    <= fill_d;
        end
    end

    // RAM-side outputs decoded purely from state.
    always_comb begin
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_DONE);
        mem_ld   = (state_q == ST_WR);
        mem_addr = '0;
        mem_in   = '0;
        if (state_q == ST_RD) begin
            mem_addr = src_ptr_q;
        end else if (state_q == ST_WR) begin
            mem_addr = dst_ptr_q;
            mem_in   = (mode_q == MODE_FILL) ? fill_q : buf_q;
        end
    end

endmodule

// File: tb/tb_ram4k_copy_engine.sv
// Self-checking bench for ram4k_copy_engine with a behavioural RAM4k
// (combinational read, write on mem_ld at the rising edge).
module tb_ram4k_copy_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [11:0] src, dst;
    logic [12:0] len;
    logic [15:0] fill_val;
    logic        busy, done;
    logic [11:0] mem_addr;
    logic [15:0] mem_in;
    logic        mem_ld;
    logic [15:0] mem_out;

    always #5 clk = ~clk;

    ram4k_copy_engine #(.ADDR_W(12), .DATA_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .fill_val (fill_val),
        .busy     (busy),
        .done     (done),
        .mem_addr (mem_addr),
        .mem_in   (mem_in),
        .mem_ld   (mem_ld),
        .mem_out  (mem_out)
    );

    // Behavioural RAM; one process owns all writes (pattern init, bench
    // pokes, engine writes).
    logic [15:0] ram     [4096];
    logic [15:0] exp_mem [4096];
    logic        init_req = 1'b0;
    logic        tb_we    = 1'b0;
    logic [11:0] tb_waddr = '0;
    logic [15:0] tb_wdata = '0;

    assign mem_out = ram[mem_addr];

    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 16'(i) ^ 16'h5A5A;
        end else if (tb_we) begin
            ram[tb_waddr] <= tb_wdata;
        end else if (mem_ld) begin
            ram[mem_addr] <= mem_in;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [15:0] d);
        tb_waddr = a;
        tb_wdata = d;
        tb_we    = 1'b1;
        @(negedge clk);
        tb_we    = 1'b0;
    endtask

    task automatic snapshot();
        for (int i = 0; i < 4096; i++) exp_mem[i] = ram[i];
    endtask

    // Pattern fill plus the specific source words the scenarios rely on.
    task automatic preload();
        @(negedge clk);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        poke(12'h010, 16'hAAAA);
        poke(12'h011, 16'hBBBB);
        poke(12'h012, 16'hCCCC);
        poke(12'h020, 16'h0001);
        poke(12'h021, 16'h0002);
        poke(12'h022, 16'h0003);
        snapshot();
    endtask

    // Reference effect of one operation on the expected-memory image:
    // forward word-by-word copy, or fill.
    task automatic apply_model(input logic m, input logic [11:0] s, input logic [11:0] d,
                               input logic [12:0] l, input logic [15:0] f);
        for (int i = 0; i < int'(l); i++) begin
            logic [11:0] sa, da;
            sa = s + 12'(i);
            da = d + 12'(i);
            exp_mem[da] = m ? f : exp_mem[sa];
        end
    endtask

    task automatic compare_ram(input string name);
        int bad = 0;
        for (int i = 0; i < 4096; i++) if (ram[i] !== exp_mem[i]) bad++;
        check(name, bad, 0);
    endtask

    logic [11:0] rd_log [16];
    logic [11:0] wr_log [16];
    int          rd_n, wr_n;

    // Issue one request and observe it until busy drops. Samples are taken
    // on falling edges; cycle 0 is the cycle after the sampling edge E0.
    // glitch_cyc >= 0 re-asserts start (with different parameters) for one
    // edge at that cycle.
    task automatic run_op(input logic m, input logic [11:0] s, input logic [11:0] d,
                          input logic [12:0] l, input logic [15:0] f, input int glitch_cyc,
                          output int busy_n, output int ld_n, output int done_n,
                          output int done_at, output logic timeout);
        busy_n = 0; ld_n = 0; done_n = 0; done_at = -1; timeout = 1'b1;
        rd_n = 0; wr_n = 0;
        mode = m; src = s; dst = d; len = l; fill_val = f;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble the request inputs: the engine must use latched copies.
        mode = ~m; src = ~s; dst = ~d; len = 13'h0005; fill_val = ~f;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (mem_ld) begin
                if (wr_n < 16) wr_log[wr_n] = mem_addr;
                wr_n++;
                ld_n++;
            end else if (busy && !done) begin
                if (rd_n < 16) rd_log[rd_n] = mem_addr;
                rd_n++;
            end
            if (done) begin
                done_n++;
                done_at = cyc;
            end
            if (!busy) begin
                timeout = 1'b0;
                break;
            end
            if (cyc == glitch_cyc) begin
                start = 1'b1; mode = 1'b1; dst = 12'h300; len = 13'd5; fill_val = 16'hDEAD;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic        mode;
        logic [11:0] src;
        logic [11:0] dst;
        logic [12:0] len;
        logic [15:0] fill;
        int          exp_busy;
        int          exp_ld;
        int          exp_done_at;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int   b_n, l_n, d_n, d_at;
        logic to;

        vecs[0] = '{1'b0, 12'h010, 12'h100, 13'd3,    16'h0000, 7,    3,    6};
        vecs[1] = '{1'b1, 12'h000, 12'h000, 13'd4096, 16'h1234, 4097, 4096, 4096};
        vecs[2] = '{1'b0, 12'hFFE, 12'h200, 13'd4,    16'h0000, 9,    4,    8};
        vecs[3] = '{1'b0, 12'h005, 12'h300, 13'd0,    16'h0000, 1,    0,    0};
        vecs[4] = '{1'b0, 12'h020, 12'h021, 13'd3,    16'h0000, 7,    3,    6};
        vecs[5] = '{1'b1, 12'h000, 12'hFFE, 13'd3,    16'hBEEF, 4,    3,    3};
        vecs[6] = '{1'b1, 12'h000, 12'h400, 13'd0,    16'h7777, 1,    0,    0};

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; fill_val = '0;
        #12;
        check("rst_busy",     32'(busy),     0);
        check("rst_done",     32'(done),     0);
        check("rst_mem_ld",   32'(mem_ld),   0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_in",   32'(mem_in),   0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven operations.
        for (int v = 0; v < 7; v++) begin
            preload();
            apply_model(vecs[v].mode, vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].fill);
            run_op(vecs[v].mode, vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].fill, -1,
                   b_n, l_n, d_n, d_at, to);
            check($sformatf("v%0d_timeout", v), 32'(to),   0);
            check($sformatf("v%0d_busy_cycles", v), b_n,   vecs[v].exp_busy);
            check($sformatf("v%0d_ld_cycles", v),   l_n,   vecs[v].exp_ld);
            check($sformatf("v%0d_done_pulses", v), d_n,   1);
            check($sformatf("v%0d_done_at", v),     d_at,  vecs[v].exp_done_at);
            compare_ram($sformatf("v%0d_ram", v));
            if (v == 0) begin
                check("copy_w0", 32'(ram[12'h100]), 32'hAAAA);
                check("copy_w1", 32'(ram[12'h101]), 32'hBBBB);
                check("copy_w2", 32'(ram[12'h102]), 32'hCCCC);
            end
            if (v == 1) begin
                check("fill_first", 32'(ram[12'h000]), 32'h1234);
                check("fill_last",  32'(ram[12'hFFF]), 32'h1234);
            end
            if (v == 2) begin
                check("wrap_rd0", 32'(rd_log[0]), 32'hFFE);
                check("wrap_rd1", 32'(rd_log[1]), 32'hFFF);
                check("wrap_rd2", 32'(rd_log[2]), 32'h000);
                check("wrap_rd3", 32'(rd_log[3]), 32'h001);
                check("wrap_wr0", 32'(wr_log[0]), 32'h200);
                check("wrap_wr3", 32'(wr_log[3]), 32'h203);
                check("wrap_rd_count", rd_n, 4);
            end
            if (v == 4) begin
                check("overlap_21", 32'(ram[12'h021]), 32'h0001);
                check("overlap_22", 32'(ram[12'h022]), 32'h0001);
                check("overlap_23", 32'(ram[12'h023]), 32'h0001);
            end
        end

        // start re-asserted while busy (mid-copy, then during DONE).
        for (int g = 0; g < 2; g++) begin
            int gc;
            gc = (g == 0) ? 2 : 6;
            preload();
            apply_model(1'b0, 12'h010, 12'h100, 13'd3, 16'h0000);
            run_op(1'b0, 12'h010, 12'h100, 13'd3, 16'h0000, gc, b_n, l_n, d_n, d_at, to);
            check($sformatf("busy_start%0d_busy", g),  b_n, 7);
            check($sformatf("busy_start%0d_done", g),  d_n, 1);
            check($sformatf("busy_start%0d_ld", g),    l_n, 3);
            compare_ram($sformatf("busy_start%0d_ram", g));
            @(negedge clk);
            check($sformatf("busy_start%0d_idle", g), 32'(busy), 0);
        end

        // Reset during the third write of a 3-word copy.
        preload();
        mode = 1'b0; src = 12'h010; dst = 12'h100; len = 13'd3; fill_val = '0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_mid_ld_before", 32'(mem_ld), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ld",   32'(mem_ld), 0);
        check("rst_mid_busy", 32'(busy),   0);
        check("rst_mid_done", 32'(done),   0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_w0", 32'(ram[12'h100]), 32'hAAAA);
        check("rst_mid_w1", 32'(ram[12'h101]), 32'hBBBB);
        check("rst_mid_w2", 32'(ram[12'h102]), 32'h5B58);

        // Fresh copy after the interrupted one.
        snapshot();
        apply_model(1'b0, 12'h010, 12'h100, 13'd3, 16'h0000);
        run_op(1'b0, 12'h010, 12'h100, 13'd3, 16'h0000, -1, b_n, l_n, d_n, d_at, to);
        check("after_rst_busy",    b_n,  7);
        check("after_rst_done_at", d_at, 6);
        check("after_rst_w2", 32'(ram[12'h102]), 32'hCCCC);
        compare_ram("after_rst_ram");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
